prefix_carry_pipe_8b: RTL

PREFIX_CARRY_PIPE_8B -- requirements
Module: prefix_carry_pipe_8b

---
 rtl/prefix_carry_pipe_8b.sv | 71 +++++++
 1 files changed

// File: rtl/prefix_carry_pipe_8b.sv
// prefix_carry_pipe_8b: 4-stage pipelined Kogge-Stone carry tree with valid/ready flow control; define PREFIX_CARRY_CNT_EN to add xfer_cnt_o
module prefix_carry_pipe_8b #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [8:0]       prop_i,
  input  logic [8:0]       gen_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [8:0]       carry_o,
  output logic [8:0]       prop_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef PREFIX_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt_o
`endif
);
  logic [3:0][8:0] g_q, g_d, r_q, r_d, g_in, r_in, p_in;
  logic [2:0][8:0] p_q, p_d;
  logic [3:0]      v_q, v_d, v_in, en;
  assign g_in = {g_q[2:0], gen_i};
  assign p_in = {p_q, prop_i};
  assign r_in = {r_q[2:0], prop_i};
  assign v_in = {v_q[2:0], valid_i};
  // a stage may load when its successor is empty or moving on; the last stage moves on ready_i
  always_comb begin
    en[3] = !v_q[3] || ready_i;
    for (int k = 2; k >= 0; k--) en[k] = !v_q[k] || en[k+1];
  end
  // one combine level per stage with span 1<<k; positions below the span keep (G,P) unchanged
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      g_d[k] = en[k] ? (g_in[k] | (p_in[k] & (g_in[k] << (1 << k)))) : g_q[k];
      r_d[k] = en[k] ? r_in[k] : r_q[k];
      v_d[k] = en[k] ? v_in[k] : v_q[k];
    end
    for (int k = 0; k < 3; k++)
      p_d[k] = en[k] ? (p_in[k] & ((p_in[k] << (1 << k)) | ((9'd1 << (1 << k)) - 9'd1))) : p_q[k];
  end
  // pipeline registers; reset drops everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
      g_q <= '0;
      p_q <= '0;
      r_q <= '0;
    end else begin
      v_q <= v_d;
      g_q <= g_d;
      p_q <= p_d;
      r_q <= r_d;
    end
  end
  assign ready_o = en[0];
  assign valid_o = v_q[3];
  assign carry_o = g_q[3];
  assign prop_o  = r_q[3];
`ifdef PREFIX_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // count output transfers, sticking at all-ones
  always_comb cnt_d = (valid_o && ready_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign xfer_cnt_o = cnt_q;
`endif
endmodule
